vrf_write_arbiter: RTL and testbench
====================================

VRF_WRITE_ARBITER -- requirements
Module: vrf_write_arbiter

Interface
REQ-001 SHALL have parameter NrWritePorts, default 3; number of write requesters (VFU, LSU, SLDU order).
REQ-002 SHALL have parameter NrReadPorts, default 3; number of hazard-query ports.
REQ-003 SHALL have parameter NrWords, default NRVREG; register file rows.
REQ-004 SHALL have parameter WordWidth, default VRFWordWidth; data bits per row.
REQ-005 SHALL have port clk_i  input  1  single clock; the block uses one clock.
REQ-006 SHALL have port rst_ni  input  1  reset; asynchronous and active-low.
REQ-007 SHALL have port req_i  input  NrWritePorts  per-requester write request.
REQ-008 SHALL have port addr_i  input  NrWritePorts x clog2(NrWords)  per-requester row address.
REQ-009 SHALL have port data_i  input  NrWritePorts x WordWidth  per-requester write data.
REQ-010 SHALL have port be_i  input  NrWritePorts x WordWidth/8  per-requester byte enables.
REQ-011 SHALL have port gnt_o  output  NrWritePorts  one-hot grant; the request completes in the cycle its grant is high.
REQ-012 SHALL have port waddr_o / wdata_o / we_o / wbe_o  output  clog2(NrWords) / WordWidth / 1 / WordWidth/8  write port toward the register file.
REQ-013 SHALL have port raddr_i  input  NrReadPorts x clog2(NrWords)  read addresses to check.
REQ-014 SHALL have port hazard_o  output  NrReadPorts  read of that row would return stale data.

Function
REQ-015 SHALL grant at most one requester per cycle, combinationally in the cycle of request (zero latency).
REQ-016 SHALL select the winner as the first requester with req_i high, searching cyclically from index rr_q upward.
REQ-017 SHALL update rr_q to (winner+1) mod NrWritePorts on every grant; with no request, rr_q SHALL be held.
REQ-018 SHALL drive we_o = |req_i, and waddr_o/wdata_o/wbe_o from the winner; with no request they SHALL be 0.
REQ-019 SHALL grant and forward a request with be_i == 0 like any other (we_o=1, wbe_o=0).
REQ-020 SHALL register the granted address and byte enables into inflight_q, with inflight_valid_q = we_o && |wbe_o, for exactly one cycle.
REQ-021 SHALL assert hazard_o[p] when (we_o && |wbe_o && raddr_i[p]==waddr_o) or (inflight_valid_q && raddr_i[p]==inflight_addr_q); the register file commits data one cycle after the write cycle.
REQ-022 SHALL treat back-to-back writes to the same row as independent; each receives its own grant.
REQ-023 SHALL require requesters to hold req_i/addr_i/data_i/be_i stable until granted; a request dropped before grant SHALL be ignored.

Reset
REQ-024 While rst_ni is low: rr_q=0 and inflight_valid_q=0; gnt_o, we_o, wbe_o and hazard_o SHALL be forced to 0 regardless of inputs.
REQ-025 A reset asserted mid-write SHALL drop the in-flight hazard. The first cycle after release SHALL arbitrate from index 0.

Structure
REQ-026 NRVREG, VRFWordWidth and the typedefs vrf_addr_t, vrf_data_t and vrf_be_t SHALL live in spatz_pkg.
REQ-027 The cyclic priority search SHALL use one instance of the common_cells lzc on the rotated request vector; no other sub-module.

Verification
REQ-028 Reset release, req_i=000 -> gnt_o=000, we_o=0, hazard_o=000, rr_q=0.
REQ-029 req_i=111 held for 4 cycles -> gnt_o sequence 001,010,100,001.
REQ-030 Only req_i[1]=1, addr=5, be=all ones, raddr_i[0]=5 -> hazard_o[0]=1 in the grant cycle and the following cycle; 0 in the third cycle.
REQ-031 req_i[2]=1 with be_i=0, addr=7, raddr_i[0]=7 -> gnt_o=100, we_o=1, wbe_o=0, hazard_o[0]=0 in both cycles.
REQ-032 rr_q=2, req_i=011 -> gnt_o=001, rr_q becomes 1.
REQ-033 rst_ni pulsed low while req_i=111 and inflight_valid_q=1 -> all outputs 0 during reset; first post-reset grant = 001.

Source files
------------

// File: rtl/spatz_pkg.sv
// Shared vector register file geometry and the row-level types used by
// the blocks that sit in front of the VRF.
package spatz_pkg;

    localparam int NRVREG       = 32;
    localparam int VRFWordWidth = 64;

    typedef logic [$clog2(NRVREG)-1:0] vrf_addr_t;
    typedef logic [VRFWordWidth-1:0]   vrf_data_t;
    typedef logic [VRFWordWidth/8-1:0] vrf_be_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter: MODE=0 counts trailing zeros (index of the
// lowest set bit), MODE=1 counts leading zeros. empty_o flags an all-zero input.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        if (MODE) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/vrf_write_arbiter.sv
// Round-robin arbiter for the single VRF write port, with zero-latency grant
// and read-after-write hazard flags covering the write and its commit cycle.
module vrf_write_arbiter
    import spatz_pkg::*;
#(
    parameter int NrWritePorts = 3,
    parameter int NrReadPorts  = 3,
    parameter int NrWords      = NRVREG,
    parameter int WordWidth    = VRFWordWidth
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NrWritePorts-1:0]                       req_i,
    input  logic [NrWritePorts-1:0][$clog2(NrWords)-1:0]  addr_i,
    input  logic [NrWritePorts-1:0][WordWidth-1:0]        data_i,
    input  logic [NrWritePorts-1:0][WordWidth/8-1:0]      be_i,
    output logic [NrWritePorts-1:0]                       gnt_o,
    output logic [$clog2(NrWords)-1:0]                    waddr_o,
    output logic [WordWidth-1:0]                          wdata_o,
    output logic                                          we_o,
    output logic [WordWidth/8-1:0]                        wbe_o,
    input  logic [NrReadPorts-1:0][$clog2(NrWords)-1:0]   raddr_i,
    output logic [NrReadPorts-1:0]                        hazard_o
);

    localparam int AddrW = $clog2(NrWords);
    localparam int BeW   = WordWidth / 8;
    localparam int IdxW  = (NrWritePorts > 1) ? $clog2(NrWritePorts) : 1;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [BeW-1:0]   be;
    } inflight_t;

    logic [IdxW-1:0]         rr_q, rr_d;
    inflight_t               inflight_q, inflight_d;
    logic                    inflight_valid_q, inflight_valid_d;
    logic [NrWritePorts-1:0] req_rot;
    logic [IdxW-1:0]         lzc_cnt;
    logic                    lzc_empty;
    logic [IdxW-1:0]         win;

    // Rotate so that position 0 of the search vector is requester rr_q.
    always_comb begin
        int idx;
        req_rot = '0;
        for (int i = 0; i < NrWritePorts; i++) begin
            idx = i + int'(rr_q);
            if (idx >= NrWritePorts) idx = idx - NrWritePorts;
            req_rot[i] = req_i[idx];
        end
    end

    lzc #(
        .WIDTH     (NrWritePorts),
        .MODE      (1'b0),
        .CNT_WIDTH (IdxW)
    ) i_lzc (
        .in_i    (req_rot),
        .cnt_o   (lzc_cnt),
        .empty_o (lzc_empty)
    );

    always_comb begin
        int w;
        int n;
        w = int'(lzc_cnt) + int'(rr_q);
        if (w >= NrWritePorts) w = w - NrWritePorts;
        n = w + 1;
        if (n >= NrWritePorts) n = 0;
        win  = IdxW'(w);
        rr_d = rr_q;
        if (!lzc_empty) rr_d = IdxW'(n);
    end

    // Outputs are held at zero while reset is asserted, whatever the inputs do.
    always_comb begin
        gnt_o   = '0;
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        wbe_o   = '0;
        if (rst_ni && !lzc_empty) begin
            gnt_o[win] = 1'b1;
            we_o       = 1'b1;
            waddr_o    = addr_i[win];
            wdata_o    = data_i[win];
            wbe_o      = be_i[win];
        end
    end

    always_comb begin
        inflight_d.addr  = waddr_o;
        inflight_d.be    = wbe_o;
        inflight_valid_d = we_o && (|wbe_o);
    end

    always_comb begin
        hazard_o = '0;
        for (int p = 0; p < NrReadPorts; p++) begin
            hazard_o[p] = rst_ni &&
                ((we_o && (|wbe_o) && (raddr_i[p] == waddr_o)) ||
                 (inflight_valid_q && (|inflight_q.be) && (raddr_i[p] == inflight_q.addr)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q             <= '0;
            inflight_q       <= '0;
            inflight_valid_q <= 1'b0;
        end else begin
            rr_q             <= rr_d;
            inflight_q       <= inflight_d;
            inflight_valid_q <= inflight_valid_d;
        end
    end

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Directed bench for vrf_write_arbiter: reset, round-robin order, hazard
// window, zero byte-enable writes, pointer wrap and reset during a write.
module tb_vrf_write_arbiter;

    logic            clk;
    logic            rst_n;
    logic [2:0]      req;
    logic [2:0][4:0] addr;
    logic [2:0][63:0] data;
    logic [2:0][7:0] be;
    logic [2:0]      gnt;
    logic [4:0]      waddr;
    logic [63:0]     wdata;
    logic            we;
    logic [7:0]      wbe;
    logic [2:0][4:0] raddr;
    logic [2:0]      hazard;

    int n_checks = 0;
    int n_fail   = 0;

    vrf_write_arbiter dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .addr_i   (addr),
        .data_i   (data),
        .be_i     (be),
        .gnt_o    (gnt),
        .waddr_o  (waddr),
        .wdata_o  (wdata),
        .we_o     (we),
        .wbe_o    (wbe),
        .raddr_i  (raddr),
        .hazard_o (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        req = 3'b000;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b111;
        addr  = '0;
        be    = '1;
        data  = '0;
        raddr = '0;
        #1;
        n_checks++;
        if (gnt !== 3'b000 || we !== 1'b0 || wbe !== 8'h00 || hazard !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_forced: gnt=%b we=%b wbe=%h hazard=%b required 000/0/00/000", gnt, we, wbe, hazard);
        end
        step();
        step();
        req = 3'b000;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 3'b000 || we !== 1'b0 || hazard !== 3'b000 || dut.rr_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: gnt=%b we=%b hazard=%b rr=%0d required 000/0/000/0", gnt, we, hazard, dut.rr_q);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [4];
        logic [4:0] exp_addr [4];
        exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
        exp_addr[0] = 5'd1;  exp_addr[1] = 5'd2;  exp_addr[2] = 5'd3;  exp_addr[3] = 5'd1;
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3;
        data[0] = 64'hA0; data[1] = 64'hA1; data[2] = 64'hA2;
        be = '1;
        raddr = {5'd30, 5'd30, 5'd30};
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (gnt !== exp_gnt[i] || we !== 1'b1 || waddr !== exp_addr[i]) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: gnt=%b we=%b waddr=%0d required %b/1/%0d", i, gnt, we, waddr, exp_gnt[i], exp_addr[i]);
            end
            step();
        end
        idle_cycle();
    endtask

    task automatic test_hazard();
        addr[1] = 5'd5;
        data[1] = 64'h1234_5678_9ABC_DEF0;
        be[1]   = 8'hFF;
        raddr[0] = 5'd5;
        raddr[1] = 5'd6;
        req = 3'b010;
        #1;
        n_checks++;
        if (gnt !== 3'b010 || waddr !== 5'd5 || wdata !== 64'h1234_5678_9ABC_DEF0 || wbe !== 8'hFF) begin
            n_fail++;
            $display("FAIL hazard_grant: gnt=%b waddr=%0d wdata=%h wbe=%h required 010/5/123456789abcdef0/ff", gnt, waddr, wdata, wbe);
        end
        n_checks++;
        if (hazard[1:0] !== 2'b01) begin
            n_fail++;
            $display("FAIL hazard_cycle0: hazard[1:0]=%b required 01", hazard[1:0]);
        end
        step();
        req = 3'b000;
        #1;
        n_checks++;
        if (hazard[1:0] !== 2'b01 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_cycle1: hazard[1:0]=%b we=%b required 01/0", hazard[1:0], we);
        end
        step();
        n_checks++;
        if (hazard !== 3'b000) begin
            n_fail++;
            $display("FAIL hazard_cycle2: hazard=%b required 000", hazard);
        end
    endtask

    task automatic test_zero_be();
        addr[2] = 5'd7;
        data[2] = 64'hBEEF;
        be[2]   = 8'h00;
        raddr[0] = 5'd7;
        req = 3'b100;
        #1;
        n_checks++;
        if (gnt !== 3'b100 || we !== 1'b1 || wbe !== 8'h00 || waddr !== 5'd7 || hazard[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_be_grant: gnt=%b we=%b wbe=%h waddr=%0d hazard0=%b required 100/1/00/7/0", gnt, we, wbe, waddr, hazard[0]);
        end
        step();
        req = 3'b000;
        #1;
        n_checks++;
        if (hazard[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_be_next: hazard0=%b required 0", hazard[0]);
        end
        step();
    endtask

    task automatic test_rr_wrap();
        be = '1;
        raddr = {5'd31, 5'd31, 5'd31};
        req = 3'b010;
        step();
        req = 3'b000;
        #1;
        n_checks++;
        if (dut.rr_q !== 2'd2) begin
            n_fail++;
            $display("FAIL wrap_setup: rr=%0d required 2", dut.rr_q);
        end
        req = 3'b011;
        #1;
        n_checks++;
        if (gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_grant: gnt=%b required 001", gnt);
        end
        step();
        n_checks++;
        if (dut.rr_q !== 2'd1 || gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL wrap_next: rr=%0d gnt=%b required 1/010", dut.rr_q, gnt);
        end
        step();
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        addr[0] = 5'd3;
        data[0] = 64'h11;
        be[0]   = 8'h0F;
        raddr[2] = 5'd3;
        req = 3'b001;
        #1;
        n_checks++;
        if (gnt !== 3'b001 || wdata !== 64'h11 || hazard[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: gnt=%b wdata=%h hazard2=%b required 001/11/1", gnt, wdata, hazard[2]);
        end
        step();
        data[0] = 64'h22;
        #1;
        n_checks++;
        if (gnt !== 3'b001 || wdata !== 64'h22 || wbe !== 8'h0F || hazard[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: gnt=%b wdata=%h wbe=%h hazard2=%b required 001/22/0f/1", gnt, wdata, wbe, hazard[2]);
        end
        step();
        idle_cycle();
    endtask

    task automatic test_reset_midwrite();
        addr = {5'd9, 5'd9, 5'd9};
        be = '1;
        raddr = {5'd9, 5'd9, 5'd9};
        req = 3'b111;
        step();
        req = 3'b000;
        #1;
        n_checks++;
        if (dut.inflight_valid_q !== 1'b1 || hazard !== 3'b111) begin
            n_fail++;
            $display("FAIL midrst_setup: inflight=%b hazard=%b required 1/111", dut.inflight_valid_q, hazard);
        end
        req = 3'b111;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 3'b000 || we !== 1'b0 || wbe !== 8'h00 || hazard !== 3'b000 || dut.inflight_valid_q !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_during: gnt=%b we=%b wbe=%h hazard=%b inflight=%b required 000/0/00/000/0", gnt, we, wbe, hazard, dut.inflight_valid_q);
        end
        step();
        n_checks++;
        if (gnt !== 3'b000 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_held: gnt=%b we=%b required 000/0", gnt, we);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 3'b001 || we !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first_grant: gnt=%b we=%b required 001/1", gnt, we);
        end
        step();
        idle_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
        data  = '0;
        be    = '0;
        raddr = '0;
        test_reset();
        test_round_robin();
        test_hazard();
        test_zero_be();
        test_rr_wrap();
        test_back_to_back();
        test_reset_midwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
